// File: rtl/scrypt_scratch_arbiter.sv
// Round-robin arbiter sharing one scratchpad SRAM port among several scrypt SMIX cores.
// One access in flight at a time; each core addresses a private region selected by its index.
module scrypt_scratch_arbiter #(
    parameter  int unsigned NUM_CORES = 4,
    parameter  int unsigned ADDR_W    = 17,
    parameter  int unsigned DATA_W    = 1024,
    parameter  int unsigned RD_LAT    = 1,
    localparam int unsigned IDX_W     = $clog2(NUM_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req_read,
    input  logic [NUM_CORES-1:0]        req_write,
    input  logic [NUM_CORES*ADDR_W-1:0] req_addr,
    input  logic [NUM_CORES*DATA_W-1:0] req_wdata,
    output logic [NUM_CORES-1:0]        ack,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        sram_read,
    output logic                        sram_write,
    output logic [ADDR_W+IDX_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]           sram_wdata,
    input  logic [DATA_W-1:0]           sram_rdata
);

    localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_ptr;
    logic [IDX_W-1:0]        r_grant;
    logic                    r_is_read;
    logic [CNT_W-1:0]        r_cnt;
    logic [NUM_CORES-1:0]    r_ack;
    logic [NUM_CORES-1:0]    r_rvalid;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_sram_read;
    logic                    r_sram_write;
    logic [ADDR_W+IDX_W-1:0] r_sram_addr;
    logic [DATA_W-1:0]       r_sram_wdata;

    logic [NUM_CORES-1:0]    w_req;
    logic [IDX_W-1:0]        w_grant;
    logic                    w_any;
    logic                    w_grant_rd;
    logic [NUM_CORES-1:0]    w_new_oh;
    logic [NUM_CORES-1:0]    w_cur_oh;

    assign w_req      = req_read | req_write;
    assign w_grant_rd = req_read[w_grant];
    assign w_new_oh   = NUM_CORES'(1) << w_grant;
    assign w_cur_oh   = NUM_CORES'(1) << r_grant;

    // First requester at or above the pointer; scanning downward lets the nearest one win.
    always_comb begin
        w_grant = r_ptr;
        w_any   = 1'b0;
        for (int i = int'(NUM_CORES) - 1; i >= 0; i--) begin
            if (w_req[IDX_W'(r_ptr + IDX_W'(i))]) begin
                w_grant = IDX_W'(r_ptr + IDX_W'(i));
                w_any   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_is_read    <= 1'b0;
            r_cnt        <= '0;
            r_ack        <= '0;
            r_rvalid     <= '0;
            r_rdata      <= '0;
            r_sram_read  <= 1'b0;
            r_sram_write <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_ack    <= '0;
            r_rvalid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_grant;
                        r_is_read    <= w_grant_rd;
                        r_sram_addr  <= {w_grant, req_addr[int'(w_grant)*ADDR_W +: ADDR_W]};
                        r_sram_wdata <= req_wdata[int'(w_grant)*DATA_W +: DATA_W];
                        r_sram_read  <= w_grant_rd;
                        r_sram_write <= !w_grant_rd;
                        // A write completes in the strobe cycle, so its ack rides with the strobe.
                        if (!w_grant_rd) begin
                            r_ack <= w_new_oh;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_sram_read  <= 1'b0;
                    r_sram_write <= 1'b0;
                    if (r_is_read) begin
                        r_cnt   <= CNT_W'(RD_LAT);
                        r_state <= S_WAIT;
                    end else begin
                        r_ptr   <= IDX_W'(r_grant + 1'b1);
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    // Stay one extra cycle after capture so the acked core can drop its request.
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata  <= sram_rdata;
                        r_ack    <= w_cur_oh;
                        r_rvalid <= w_cur_oh;
                        r_cnt    <= '0;
                    end else if (r_cnt == '0) begin
                        r_ptr   <= IDX_W'(r_grant + 1'b1);
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ack        = r_ack;
    assign rvalid     = r_rvalid;
    assign rdata      = r_rdata;
    assign sram_read  = r_sram_read;
    assign sram_write = r_sram_write;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_scrypt_scratch_arbiter.sv
// Directed scoreboard bench for scrypt_scratch_arbiter: one instance with RD_LAT=1 for the
// full sequence and a second with RD_LAT=3 for the longer read latency.
module tb_scrypt_scratch_arbiter;

    localparam int unsigned NC = 4;
    localparam int unsigned AW = 17;
    localparam int unsigned DW = 1024;
    localparam int unsigned SW = AW + 2;

    logic          clk;
    logic          rst;
    logic [NC-1:0] req_read, req_write, ack, rvalid;
    logic [NC*AW-1:0] req_addr;
    logic [NC*DW-1:0] req_wdata;
    logic [DW-1:0] rdata, sram_wdata, sram_rdata;
    logic          sram_read, sram_write;
    logic [SW-1:0] sram_addr;

    logic [NC-1:0] req_read3, req_write3, ack3, rvalid3;
    logic [NC*AW-1:0] req_addr3;
    logic [NC*DW-1:0] req_wdata3;
    logic [DW-1:0] rdata3, sram_wdata3, sram_rdata3;
    logic          sram_read3, sram_write3;
    logic [SW-1:0] sram_addr3;

    scrypt_scratch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rvalid(rvalid),
        .rdata(rdata), .sram_read(sram_read), .sram_write(sram_write),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata));

    scrypt_scratch_arbiter #(.NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .req_read(req_read3), .req_write(req_write3),
        .req_addr(req_addr3), .req_wdata(req_wdata3), .ack(ack3), .rvalid(rvalid3),
        .rdata(rdata3), .sram_read(sram_read3), .sram_write(sram_write3),
        .sram_addr(sram_addr3), .sram_wdata(sram_wdata3), .sram_rdata(sram_rdata3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [DW-1:0] JUNK  = {32{32'h0BAD_0BAD}};
    localparam logic [DW-1:0] BEEF  = {32{32'hDEAD_BEEF}};
    localparam logic [DW-1:0] PAT_A = {128{8'hA5}};
    localparam logic [DW-1:0] PAT_3 = {16{64'h0123_4567_89AB_CDEF}};
    localparam logic [DW-1:0] PAT_0 = {16{64'hC0DE_0000_FACE_0000}};
    localparam logic [DW-1:0] PAT_2 = {16{64'h2222_3333_4444_5555}};

    // SRAM models: read data appears RD_LAT cycles after the strobe, junk otherwise.
    logic [DW-1:0] mem [logic [SW-1:0]];
    logic [DW-1:0] p1;
    logic [DW-1:0] p3 [3];
    int n_wr = 0;
    int n_rd = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [SW-1:0] a);
        if (mem.exists(a)) return mem[a];
        return {32{32'h5A5A_0000}};
    endfunction

    assign sram_rdata  = p1;
    assign sram_rdata3 = p3[2];

    always @(posedge clk) begin
        p1    <= sram_read ? mem_rd(sram_addr) : JUNK;
        p3[0] <= sram_read3 ? mem_rd(sram_addr3) : JUNK;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        if (sram_write) n_wr <= n_wr + 1;
        if (sram_read)  n_rd <= n_rd + 1;
    end

    typedef struct {
        logic [NC-1:0] ack;
        logic [NC-1:0] rvalid;
        logic [DW-1:0] rdata;
        bit            rd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed(low)=%0h expected(low)=%0h", tag, obs[191:0], exp[191:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NC-1:0] a, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        e.ack    = a;
        e.rvalid = rd ? a : '0;
        e.rdata  = d;
        e.rd     = rd;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit d3, input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((d3 ? ack3 : ack) == '0) && n < budget);
        chk("ack_seen", 32'((d3 ? ack3 : ack) != '0), 32'd1);
    endtask

    task automatic check_pop(input string tag, input bit d3);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"},    32'(d3 ? ack3 : ack),       32'(e.ack));
            chk({tag, "_rvalid"}, 32'(d3 ? rvalid3 : rvalid), 32'(e.rvalid));
            if (e.rd) chkd({tag, "_rdata"}, d3 ? rdata3 : rdata, e.rdata);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n;
        int wr0, rd0;

        mem[{2'd1, 17'h1FF80}] = BEEF;
        mem[{2'd3, 17'h00100}] = PAT_3;
        mem[{2'd0, 17'h00040}] = PAT_0;
        mem[{2'd2, 17'h00200}] = PAT_2;
        req_read3  = '0;
        req_write3 = '0;
        req_addr3  = '0;
        req_wdata3 = '0;

        // Reset with random requests applied
        rst       = 1'b1;
        req_read  = 4'($urandom);
        req_write = 4'($urandom);
        req_addr  = {4{17'($urandom)}};
        req_wdata = {128{32'($urandom)}};
        repeat (3) tick();
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chkd("rst_rdata", rdata, '0);
        chk("rst_strobes", 32'({sram_read, sram_write}), 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chkd("rst_wdata", sram_wdata, '0);

        req_read  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b0;
        tick();

        // Core 2 write
        req_write[2]          = 1'b1;
        req_addr[2*AW +: AW]  = 17'h00080;
        req_wdata[2*DW +: DW] = PAT_A;
        push(4'b0100, 1'b0, '0);
        wait_ack(1'b0, 10, n);
        chk("wr_lat", 32'(n), 32'd1);
        check_pop("wr2", 1'b0);
        chk("wr_strobe", 32'({sram_read, sram_write}), 32'b01);
        chk("wr_addr", 32'(sram_addr), 32'({2'd2, 17'h00080}));
        chkd("wr_wdata", sram_wdata, PAT_A);
        req_write[2] = 1'b0;
        tick();
        chk("wr_after", 32'({ack, sram_write}), 32'd0);

        // Core 1 read, RD_LAT=1
        req_read[1]         = 1'b1;
        req_addr[1*AW +: AW] = 17'h1FF80;
        push(4'b0010, 1'b1, BEEF);
        tick();
        chk("rd_strobe", 32'({sram_read, sram_write}), 32'b10);
        chk("rd_addr", 32'(sram_addr), 32'({2'd1, 17'h1FF80}));
        wait_ack(1'b0, 10, n);
        chk("rd_lat", 32'(n + 1), 32'd3);
        check_pop("rd1", 1'b0);
        req_read[1] = 1'b0;

        // Core 0 write; rdata must stay held
        req_write[0]         = 1'b1;
        req_addr[0*AW +: AW] = 17'h00010;
        push(4'b0001, 1'b0, '0);
        wait_ack(1'b0, 10, n);
        check_pop("wr0", 1'b0);
        chkd("rdata_held", rdata, BEEF);
        req_write[0] = 1'b0;
        tick();

        // Core 1 read, RD_LAT=3
        req_read3[1]          = 1'b1;
        req_addr3[1*AW +: AW] = 17'h1FF80;
        push(4'b0010, 1'b1, BEEF);
        wait_ack(1'b1, 20, n);
        chk("rd3_lat", 32'(n), 32'd5);
        check_pop("rd3", 1'b1);
        req_read3[1] = 1'b0;
        tick();
        chkd("rd3_held", rdata3, BEEF);

        // Round-robin: all cores write continuously from reset
        rst = 1'b1;
        tick();
        for (int i = 0; i < int'(NC); i++) begin
            req_write[i]         = 1'b1;
            req_addr[i*AW +: AW] = 17'(17'h00400 + i);
        end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            push(4'(1 << (k % 4)), 1'b0, '0);
            wait_ack(1'b0, 10, n);
            chk($sformatf("rr%0d_gap", k), 32'(n), (k == 0) ? 32'd1 : 32'd2);
            check_pop($sformatf("rr%0d", k), 1'b0);
            chk($sformatf("rr%0d_addr", k), 32'(sram_addr), 32'({2'(k % 4), 17'(17'h00400 + k % 4)}));
        end
        req_write = '0;
        repeat (3) tick();

        // Read+write conflict on core 3: read only
        wr0 = n_wr;
        rd0 = n_rd;
        req_read[3]          = 1'b1;
        req_write[3]         = 1'b1;
        req_addr[3*AW +: AW] = 17'h00100;
        req_wdata[3*DW +: DW] = ~PAT_3;
        push(4'b1000, 1'b1, PAT_3);
        wait_ack(1'b0, 10, n);
        chk("rw_lat", 32'(n), 32'd3);
        check_pop("rw3", 1'b0);
        req_read[3]  = 1'b0;
        req_write[3] = 1'b0;
        tick();
        chk("rw_no_write", 32'(n_wr - wr0), 32'd0);
        chk("rw_one_read", 32'(n_rd - rd0), 32'd1);

        // Core 0 read dropped during WAIT; pending core 1 write follows
        req_read[0]          = 1'b1;
        req_addr[0*AW +: AW] = 17'h00040;
        req_write[1]         = 1'b1;
        req_addr[1*AW +: AW] = 17'h00777;
        push(4'b0001, 1'b1, PAT_0);
        push(4'b0010, 1'b0, '0);
        tick();
        tick();
        req_read[0] = 1'b0;
        wait_ack(1'b0, 10, n);
        chk("drop_lat", 32'(n), 32'd1);
        check_pop("drop0", 1'b0);
        wait_ack(1'b0, 10, n);
        chk("next1_lat", 32'(n), 32'd2);
        check_pop("next1", 1'b0);
        chk("next1_addr", 32'(sram_addr), 32'({2'd1, 17'h00777}));
        req_write[1] = 1'b0;
        tick();

        // Reset during a core 2 read in WAIT
        req_read[2]          = 1'b1;
        req_addr[2*AW +: AW] = 17'h00200;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'({ack, rvalid}), 32'd0);
        chkd("mid_rst_rdata", rdata, '0);
        tick();
        tick();
        chk("mid_rst_hold", 32'({ack, rvalid, sram_read, sram_write}), 32'd0);
        req_read[2]          = 1'b0;
        req_write[0]         = 1'b1;
        req_write[3]         = 1'b1;
        req_addr[0*AW +: AW] = 17'h00001;
        req_addr[3*AW +: AW] = 17'h00003;
        sb.delete();
        push(4'b0001, 1'b0, '0);
        push(4'b1000, 1'b0, '0);
        rst = 1'b0;
        wait_ack(1'b0, 10, n);
        chk("post_rst_lat", 32'(n), 32'd1);
        check_pop("post_rst0", 1'b0);
        req_write[0] = 1'b0;
        wait_ack(1'b0, 10, n);
        check_pop("post_rst3", 1'b0);
        req_write[3] = 1'b0;
        tick();
        chk("end_idle", 32'({ack, rvalid, sram_read, sram_write}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
